// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter among four byte-stream requesters. Arbitration
// is round-robin and happens only between packets. Once a port is granted,
// it keeps the transmitter until the byte flagged req_last has been sent.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req_valid  [3:0]  per-port byte available
//   req_data   [31:0] per-port byte, port i at [8i+7:8i]
//   req_last   [3:0]  per-port end-of-packet flag, qualified by req_valid
//   req_ready  [3:0]  combinational byte accept, one-hot or zero
//   tx_start          registered one-cycle start pulse to the transmitter
//   tx_data    [7:0]  registered byte, held until the next accept
//   tx_busy           transmitter busy, rises the cycle after tx_start
//   grant_id   [1:0]  port currently owning the transmitter
//   active            high whenever the FSM is not idle
//   byte_sent         one-cycle pulse when a byte completes
//   ack_err           sticky: transmitter never raised tx_busy after a start
// -----------------------------------------------------------------------------
module uart_tx_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_last,
  output logic [3:0]  req_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic [1:0]  grant_id,
  output logic        active,
  output logic        byte_sent,
  output logic        ack_err
);

  localparam int unsigned NPORTS = 4;
  localparam int unsigned PW     = 2;
  localparam int unsigned DW     = 8;
  localparam int unsigned CW     = 4;
  localparam logic [CW-1:0] ACK_LIMIT = CW'(15);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND      = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  state_e          state_q;
  logic [PW-1:0]   grant_q;
  logic [PW-1:0]   last_grant_q;
  logic            last_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            tx_start_q;
  logic [DW-1:0]   tx_data_q;
  logic            active_q;
  logic            byte_sent_q;
  logic            ack_err_q;

  logic [PW-1:0]   win_c;
  logic            accept_c;
  logic [DW-1:0]   sel_byte_c;
  logic            sel_last_c;

  // Round-robin winner: first valid port after last_grant, wrapping around.
  always_comb begin
    logic [PW-1:0] cand;
    logic          found;
    win_c = last_grant_q;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= NPORTS; i++) begin
      cand = last_grant_q + PW'(i);
      if (!found && req_valid[cand]) begin
        win_c = cand;
        found = 1'b1;
      end
    end
  end

  // Byte and last flag of the granted port.
  assign sel_byte_c = req_data[{grant_q, 3'b000} +: DW];
  assign sel_last_c = req_last[grant_q];

  // Accept only while sending, the owner has data and the UART is free;
  // reset suppresses the accept in the same cycle.
  assign accept_c  = (state_q == S_SEND) && req_valid[grant_q] && !tx_busy && !reset;
  assign req_ready = accept_c ? NPORTS'(4'b0001 << grant_q) : '0;

  assign cnt_d = cnt_q + CW'(1);

  // Arbiter FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= PW'(3);
      last_q       <= 1'b0;
      cnt_q        <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      active_q     <= 1'b0;
      byte_sent_q  <= 1'b0;
      ack_err_q    <= 1'b0;
    end else begin
      tx_start_q  <= 1'b0;
      byte_sent_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|req_valid) begin
            grant_q  <= win_c;
            state_q  <= S_SEND;
            active_q <= 1'b1;
          end
        end
        S_SEND: begin
          // Packet lock: with no data from the owner, just hold the grant.
          if (accept_c) begin
            tx_data_q  <= sel_byte_c;
            last_q     <= sel_last_c;
            tx_start_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (tx_busy) begin
            state_q <= S_WAIT_DONE;
          end else begin
            cnt_q <= cnt_d;
            // Give up waiting once 15 cycles have passed without tx_busy.
            if (cnt_d == ACK_LIMIT) begin
              ack_err_q <= 1'b1;
              state_q   <= S_WAIT_DONE;
            end
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            byte_sent_q <= 1'b1;
            if (last_q) begin
              last_grant_q <= grant_q;
              state_q      <= S_IDLE;
              active_q     <= 1'b0;
            end else begin
              state_q <= S_SEND;
            end
          end
        end
        default: begin
          state_q  <= S_IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign grant_id  = grant_q;
  assign active    = active_q;
  assign byte_sent = byte_sent_q;
  assign ack_err   = ack_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter: per-port byte sources, a simple UART
// busy model, and a monitor that logs accepts, starts and completions.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        byte_sent;
  logic        ack_err;

  always #5 clk = ~clk;

  uart_tx_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active),
    .byte_sent (byte_sent),
    .ack_err   (ack_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte sources: {last, data} entries per port.
  logic [8:0] src_mem [4][8];
  int         src_len [4];
  int         src_pos [4];
  logic       src_en  [4];
  logic       pop     [4];

  // UART model: busy for 3 cycles starting the cycle after tx_start.
  logic model_busy = 1'b0;
  logic hold_busy  = 1'b0;
  logic dead       = 1'b0;
  int   bcnt       = 0;
  assign tx_busy = model_busy | hold_busy;

  always @(posedge clk) begin
    if (reset) begin
      model_busy <= 1'b0;
      bcnt       <= 0;
    end else if (tx_start && !dead) begin
      model_busy <= 1'b1;
      bcnt       <= 3;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) model_busy <= 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor logs.
  int   acc_port [$];
  int   acc_data [$];
  int   st_data  [$];
  int   acc_cyc  = 0;
  int   st_cyc   = 0;
  int   err_cyc  = -1;
  int   nsent    = 0;

  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (req_ready[p]) begin
        pop[p] = 1'b1;
        acc_port.push_back(p);
        acc_data.push_back(int'(req_data[8*p +: 8]));
        acc_cyc = cyc;
      end
    end
    if (tx_start) begin
      st_data.push_back(int'(tx_data));
      st_cyc = cyc;
    end
    if (byte_sent) nsent++;
    if (ack_err && err_cyc < 0) err_cyc = cyc;
  end

  task automatic drive_ports();
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    v = '0; l = '0; d = '0;
    for (int p = 0; p < 4; p++) begin
      if (src_en[p] && src_pos[p] < src_len[p]) begin
        v[p]         = 1'b1;
        d[8*p +: 8]  = src_mem[p][src_pos[p]][7:0];
        l[p]         = src_mem[p][src_pos[p]][8];
      end
    end
    req_valid = v;
    req_data  = d;
    req_last  = l;
  endtask

  // Source driver: retire accepted bytes, then present the next ones.
  always begin
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) begin
      if (pop[p]) begin
        src_pos[p]++;
        pop[p] = 1'b0;
      end
    end
    drive_ports();
  end

  task automatic clear_src();
    for (int p = 0; p < 4; p++) begin
      src_len[p] = 0;
      src_pos[p] = 0;
      src_en[p]  = 1'b1;
      pop[p]     = 1'b0;
    end
  endtask

  task automatic clear_logs();
    acc_port.delete();
    acc_data.delete();
    st_data.delete();
    nsent   = 0;
    err_cyc = -1;
  endtask

  task automatic push(input int p, input logic [7:0] d, input logic l);
    src_mem[p][src_len[p]] = {l, d};
    src_len[p]++;
  endtask

  function automatic bit all_done();
    for (int p = 0; p < 4; p++)
      if (src_pos[p] != src_len[p]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_src();
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(all_done() && !active) && n < budget);
    check(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic check_order(input string tag, input int ports[], input int data[]);
    check({tag, " count"}, 32'(acc_port.size()), 32'(ports.size()));
    for (int i = 0; i < ports.size(); i++) begin
      check($sformatf("%s port[%0d]", tag, i), 32'(acc_port[i]), 32'(ports[i]));
      check($sformatf("%s data[%0d]", tag, i), 32'(acc_data[i]), 32'(data[i]));
    end
  endtask

  initial begin
    int n;
    int bad;
    clear_src();
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst tx_start",  32'(tx_start),  32'd0);
    check("rst tx_data",   32'(tx_data),   32'd0);
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst grant_id",  32'(grant_id),  32'd0);
    check("rst active",    32'(active),    32'd0);
    check("rst byte_sent", 32'(byte_sent), 32'd0);
    check("rst ack_err",   32'(ack_err),   32'd0);

    // Single one-byte packet on port 2.
    clear_logs();
    push(2, 8'hA5, 1'b1);
    wait_idle("t1 done", 100);
    check_order("t1", '{2}, '{8'hA5});
    check("t1 starts",    32'(st_data.size()), 32'd1);
    check("t1 st data",   32'(st_data[0]), 32'hA5);
    check("t1 latency",   32'(st_cyc - acc_cyc), 32'd1);
    check("t1 sent",      32'(nsent), 32'd1);
    check("t1 grant",     32'(grant_id), 32'd2);
    check("t1 tx_data",   32'(tx_data), 32'hA5);

    // Contention from reset: order 0,1,3, then 0 again.
    do_reset(2);
    clear_logs();
    push(0, 8'h01, 1'b1);
    push(1, 8'h02, 1'b1);
    push(3, 8'h03, 1'b1);
    wait_idle("t2 done a", 200);
    push(0, 8'h04, 1'b1);
    wait_idle("t2 done b", 100);
    check_order("t2", '{0, 1, 3, 0}, '{8'h01, 8'h02, 8'h03, 8'h04});
    check("t2 sent", 32'(nsent), 32'd4);

    // Packet lock: port 1 three bytes before waiting port 0.
    clear_logs();
    push(1, 8'h11, 1'b0);
    push(1, 8'h22, 1'b0);
    push(1, 8'h33, 1'b1);
    push(0, 8'h44, 1'b1);
    wait_idle("t3 done", 200);
    check_order("t3", '{1, 1, 1, 0}, '{8'h11, 8'h22, 8'h33, 8'h44});
    check("t3 sent", 32'(nsent), 32'd4);

    // Stall: port 3 drops valid mid-packet, port 0 must not be served.
    clear_logs();
    push(3, 8'h55, 1'b0);
    push(3, 8'h66, 1'b1);
    push(0, 8'h77, 1'b1);
    n = 0;
    while (acc_port.size() == 0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t4 first accept", 32'(n < 50), 32'd1);
    src_en[3] = 1'b0;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (grant_id != 2'd3 || req_ready != 4'd0) bad++;
    end
    check("t4 stall bad",  32'(bad), 32'd0);
    check("t4 stall accs", 32'(acc_port.size()), 32'd1);
    check("t4 stall act",  32'(active), 32'd1);
    src_en[3] = 1'b1;
    wait_idle("t4 done", 200);
    check_order("t4", '{3, 3, 0}, '{8'h55, 8'h66, 8'h77});

    // Busy transmitter holds SEND without accepting.
    clear_logs();
    hold_busy = 1'b1;
    push(1, 8'h99, 1'b1);
    repeat (6) @(negedge clk);
    check("t5 hold accs",  32'(acc_port.size()), 32'd0);
    check("t5 hold act",   32'(active), 32'd1);
    check("t5 hold grant", 32'(grant_id), 32'd1);
    hold_busy = 1'b0;
    wait_idle("t5 done", 100);
    check_order("t5", '{1}, '{8'h99});

    // Dead transmitter: ack_err after 15 waiting cycles, FSM completes.
    clear_logs();
    dead = 1'b1;
    push(2, 8'hC3, 1'b1);
    wait_idle("t6 done", 100);
    check("t6 ack_err", 32'(ack_err), 32'd1);
    check("t6 err time", 32'(err_cyc - st_cyc), 32'd15);
    check("t6 sent",    32'(nsent), 32'd1);
    check("t6 starts",  32'(st_data.size()), 32'd1);
    dead = 1'b0;

    // ack_err is sticky across a good transfer.
    clear_logs();
    push(0, 8'h5A, 1'b1);
    wait_idle("t7 done", 100);
    check_order("t7", '{0}, '{8'h5A});
    check("t7 ack_err", 32'(ack_err), 32'd1);

    // Reset while in WAIT_DONE abandons the packet.
    clear_logs();
    push(1, 8'hE1, 1'b0);
    push(1, 8'hE2, 1'b1);
    n = 0;
    while (!tx_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t8 busy seen", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_src();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("t8 active",    32'(active),    32'd0);
    check("t8 grant",     32'(grant_id),  32'd0);
    check("t8 tx_start",  32'(tx_start),  32'd0);
    check("t8 tx_data",   32'(tx_data),   32'd0);
    check("t8 req_ready", 32'(req_ready), 32'd0);
    check("t8 byte_sent", 32'(byte_sent), 32'd0);
    check("t8 ack_err",   32'(ack_err),   32'd0);
    check("t8 accs",      32'(acc_port.size()), 32'd1);
    clear_logs();
    push(3, 8'hF3, 1'b1);
    push(0, 8'hF0, 1'b1);
    wait_idle("t8 done", 200);
    check_order("t8", '{0, 3}, '{8'hF0, 8'hF3});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have no parameters; it SHALL serve exactly 4 requester ports (index 0..3).
REQ-002 clk  input  1  clock; all logic SHALL be clocked on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  4  per-port byte available.
REQ-005 req_data  input  32  per-port byte; port i at bits [8i+7:8i].
REQ-006 req_last  input  4  per-port flag marking the final byte of a packet; sampled with the byte.
REQ-007 req_ready  output  4  per-port byte accept; combinational, one-hot or zero.
REQ-008 tx_start  output  1  registered one-cycle start pulse to the UART transmitter.
REQ-009 tx_data  output  8  registered byte to the UART transmitter; held stable from the start pulse until the next accept.
REQ-010 tx_busy  input  1  UART transmitter busy; rises one cycle after tx_start is sampled, falls when the stop bit ends.
REQ-011 grant_id  output  2  index of the port currently owning the transmitter.
REQ-012 active  output  1  high whenever state is not IDLE.
REQ-013 byte_sent  output  1  one-cycle pulse when a byte's transmission completes.
REQ-014 ack_err  output  1  sticky error flag: tx_busy not seen after a start.

Function
REQ-015 FSM states SHALL be IDLE, SEND, WAIT_ACK, WAIT_DONE.
REQ-016 IDLE: if any req_valid bit is high, the block SHALL pick the winner round-robin, searching from (last_grant+1) mod 4 upward with wrap, then load grant_id, go to SEND; if no req_valid bit is high, it SHALL stay in IDLE.
REQ-017 SEND: when req_valid[grant_id]=1 and tx_busy=0, the block SHALL assert req_ready[grant_id] that cycle, latch req_data into tx_data, latch req_last, set tx_start=1 for the next cycle only, and go to WAIT_ACK.
REQ-018 SEND with req_valid[grant_id]=0 SHALL hold state and grant (packet lock), ignoring all other ports.
REQ-019 SEND with tx_busy=1 SHALL hold without accepting.
REQ-020 WAIT_ACK SHALL count cycles (4-bit counter); on tx_busy=1 it SHALL go to WAIT_DONE; if the counter reaches 15 without tx_busy, it SHALL set ack_err=1 and go to WAIT_DONE.
REQ-021 WAIT_DONE: on tx_busy=0, the block SHALL pulse byte_sent for one cycle.
REQ-022 WAIT_DONE exit when the latched last=1: the block SHALL store last_grant=grant_id and go to IDLE.
REQ-023 WAIT_DONE exit when the latched last=0: the block SHALL go to SEND with the same grant.
REQ-024 req_ready SHALL be all-zero outside the SEND accept cycle; at most one byte SHALL be accepted per transmission.
REQ-025 Latency: an accept in cycle N SHALL produce tx_start in cycle N+1; the next accept SHALL occur no earlier than the cycle after tx_busy falls.
REQ-026 Requests arriving on other ports during a packet SHALL wait; arbitration SHALL occur only in IDLE.
REQ-027 req_last on a single byte SHALL form a one-byte packet.

Reset
REQ-028 Reset SHALL force state=IDLE, tx_start=0, tx_data=0, req_ready=0, grant_id=0, last_grant=3 (port 0 wins first), active=0, byte_sent=0, ack_err=0, counter=0.
REQ-029 Reset asserted mid-packet SHALL abandon the packet with no further accepts; reset SHALL take priority over all other inputs in the same cycle.
REQ-030 ack_err SHALL clear only on reset.

Verification
REQ-031 Single port: port 2 sends 0xA5 with last=1 -> req_ready[2] pulses once, tx_start the next cycle with tx_data=0xA5, one byte_sent, return to IDLE, grant_id=2.
REQ-032 Contention: ports 0,1,3 all valid with one-byte packets -> service order 0,1,3, then 0 again if it is re-requested.
REQ-033 Packet lock: port 1 sends 3 bytes {0x11,0x22,0x33 last} while port 0 is valid throughout -> all three port-1 bytes are sent before port 0 is granted.
REQ-034 Stall: port 3 drops valid for 10 cycles mid-packet while port 0 is valid -> grant stays 3, no accept on port 0.
REQ-035 Dead transmitter: tx_busy is tied 0 after a start -> ack_err=1 after 15 WAIT_ACK cycles, byte_sent pulses, FSM proceeds.
REQ-036 Reset while in WAIT_DONE -> next cycle IDLE, all outputs at reset values; port 0 wins the next arbitration.
